// File: rtl/vote_result_tally.sv
// Vote tally engine: snapshots four candidate counts, scans them one per cycle
// to find the winner, tie flag and total, then shows the result on the LEDs.
module vote_result_tally #(
  parameter int BLINK_CYCLES = 10,
  parameter int TOTAL_W      = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         cand1_vote,
  input  logic [7:0]         cand2_vote,
  input  logic [7:0]         cand3_vote,
  input  logic [7:0]         cand4_vote,
  output logic               busy,
  output logic               done,
  output logic [2:0]         winner_id,
  output logic [7:0]         winner_count,
  output logic               tie,
  output logic [TOTAL_W-1:0] total_votes,
  output logic [7:0]         leds
);

  localparam int CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE, SHOW} state_t;

  state_t             state;
  logic [7:0]         snap [4];
  logic [1:0]         idx;
  logic [7:0]         best;
  logic [2:0]         best_id;
  logic               run_tie;
  logic [TOTAL_W-1:0] sum;
  logic [CNT_W-1:0]   blink_cnt;
  logic               blink_off;

  logic               launch;
  logic [7:0]         cur;
  logic [7:0]         step_best;
  logic [2:0]         step_id;
  logic               step_tie;
  logic [TOTAL_W-1:0] step_sum;
  logic [CNT_W-1:0]   blink_cnt_nxt;
  logic               blink_off_nxt;
  logic [7:0]         blink_leds;

  assign launch = start && (state == IDLE || state == SHOW);

  // One comparison step on the candidate selected by idx; equal counts keep the lower index.
  always_comb begin
    cur       = snap[idx];
    step_best = best;
    step_id   = best_id;
    step_tie  = run_tie;
    step_sum  = sum + TOTAL_W'(cur);
    if (cur > best) begin
      step_best = cur;
      step_id   = {1'b0, idx} + 3'd1;
      step_tie  = 1'b0;
    end else if (cur == best && cur != 8'd0) begin
      step_tie  = 1'b1;
    end
  end

  always_comb begin
    blink_cnt_nxt = blink_cnt + CNT_W'(1);
    blink_off_nxt = blink_off;
    if (blink_cnt == CNT_W'(BLINK_CYCLES - 1)) begin
      blink_cnt_nxt = '0;
      blink_off_nxt = ~blink_off;
    end
    blink_leds = (tie && blink_off_nxt) ? 8'h00 : winner_count;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      winner_id    <= '0;
      winner_count <= '0;
      tie          <= 1'b0;
      total_votes  <= '0;
      leds         <= '0;
      idx          <= '0;
      best         <= '0;
      best_id      <= '0;
      run_tie      <= 1'b0;
      sum          <= '0;
      blink_cnt    <= '0;
      blink_off    <= 1'b0;
      for (int i = 0; i < 4; i++) snap[i] <= '0;
    end else if (launch) begin
      state     <= SCAN;
      busy      <= 1'b1;
      done      <= 1'b0;
      leds      <= '0;
      snap[0]   <= cand1_vote;
      snap[1]   <= cand2_vote;
      snap[2]   <= cand3_vote;
      snap[3]   <= cand4_vote;
      idx       <= '0;
      best      <= '0;
      best_id   <= '0;
      run_tie   <= 1'b0;
      sum       <= '0;
      blink_cnt <= '0;
      blink_off <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          leds <= '0;
        end
        SCAN: begin
          best    <= step_best;
          best_id <= step_id;
          run_tie <= step_tie;
          sum     <= step_sum;
          idx     <= idx + 2'd1;
          if (idx == 2'd3) begin
            state        <= DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            winner_id    <= step_id;
            winner_count <= step_best;
            tie          <= step_tie;
            total_votes  <= step_sum;
            leds         <= step_best;
            blink_cnt    <= '0;
            blink_off    <= 1'b0;
          end
        end
        DONE, SHOW: begin
          state     <= SHOW;
          done      <= 1'b0;
          blink_cnt <= blink_cnt_nxt;
          blink_off <= blink_off_nxt;
          leds      <= blink_leds;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_result_tally.sv
// Self-checking bench for vote_result_tally: directed vector table, multi-cycle
// corner sequences and randomized tallies against a reference model.
module tb_vote_result_tally;

  localparam int B  = 10;
  localparam int TW = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    cand1_vote, cand2_vote, cand3_vote, cand4_vote;
  logic          busy, done, tie;
  logic [2:0]    winner_id;
  logic [7:0]    winner_count, leds;
  logic [TW-1:0] total_votes;

  int tests_run = 0;
  int tests_failed = 0;

  vote_result_tally #(.BLINK_CYCLES(B), .TOTAL_W(TW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .cand1_vote(cand1_vote), .cand2_vote(cand2_vote),
    .cand3_vote(cand3_vote), .cand4_vote(cand4_vote),
    .busy(busy), .done(done), .winner_id(winner_id),
    .winner_count(winner_count), .tie(tie),
    .total_votes(total_votes), .leds(leds)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] v1, v2, v3, v4;
    int         e_id, e_cnt, e_tie, e_tot;
  } vec_t;

  vec_t table_v [7];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] a, b, c, d, input logic s);
    cand1_vote = a;
    cand2_vote = b;
    cand3_vote = c;
    cand4_vote = d;
    start      = s;
  endtask

  // Reference: largest count wins, lowest index on equal counts, tie when the top count is shared.
  task automatic model(input logic [7:0] a, b, c, d, output int id, output int cnt, output int t, output int tot);
    int v [4];
    int hits;
    v = '{int'(a), int'(b), int'(c), int'(d)};
    cnt = 0; id = 0; hits = 0; tot = 0;
    foreach (v[i]) begin
      tot += v[i];
      if (v[i] > cnt) cnt = v[i];
    end
    foreach (v[i]) if (v[i] == cnt && cnt != 0) begin
      hits++;
      if (id == 0) id = i + 1;
    end
    t = (hits >= 2) ? 1 : 0;
  endtask

  function automatic int exp_leds(input int cnt, input int t, input int k);
    return (t != 0 && ((k / B) % 2) == 1) ? 0 : cnt;
  endfunction

  // Full tally from a start pulse in cycle 0 through the display phase; optional input scramble mid-scan.
  task automatic run_tally(input string name, input logic [7:0] a, b, c, d,
                           input int e_id, e_cnt, e_tie, e_tot, input bit scramble);
    next_cycle();
    applyStimulus(a, b, c, d, 1'b1);
    next_cycle();
    start = 1'b0;
    if (scramble) applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    for (int k = 1; k <= 4; k++) begin
      checkOutput({name, " busy"}, busy, 1);
      checkOutput({name, " done_scan"}, done, 0);
      checkOutput({name, " leds_scan"}, leds, 0);
      next_cycle();
    end
    checkOutput({name, " done"}, done, 1);
    checkOutput({name, " busy_done"}, busy, 0);
    checkOutput({name, " winner_id"}, winner_id, e_id);
    checkOutput({name, " winner_count"}, winner_count, e_cnt);
    checkOutput({name, " tie"}, tie, e_tie);
    checkOutput({name, " total_votes"}, total_votes, e_tot);
    for (int k = 0; k < 4 * B + 2; k++) begin
      checkOutput({name, " leds"}, leds, exp_leds(e_cnt, e_tie, k));
      if (k == 1) checkOutput({name, " done_pulse"}, done, 0);
      next_cycle();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int id, cnt, t, tot;
    logic [7:0] r [4];

    table_v[0] = '{5,   9,   3,   2,   2, 9,   0, 19};
    table_v[1] = '{7,   3,   7,   1,   1, 7,   1, 18};
    table_v[2] = '{0,   0,   0,   0,   0, 0,   0, 0};
    table_v[3] = '{255, 255, 255, 255, 1, 255, 1, 1020};
    table_v[4] = '{1,   2,   3,   4,   4, 4,   0, 10};
    table_v[5] = '{0,   6,   6,   0,   2, 6,   1, 12};
    table_v[6] = '{8,   8,   9,   0,   3, 9,   0, 25};

    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 1'b0);
    next_cycle();
    next_cycle();
    checkOutput("rst busy", busy, 0);
    checkOutput("rst done", done, 0);
    checkOutput("rst winner_id", winner_id, 0);
    checkOutput("rst winner_count", winner_count, 0);
    checkOutput("rst tie", tie, 0);
    checkOutput("rst total", total_votes, 0);
    checkOutput("rst leds", leds, 0);
    reset = 1'b0;
    next_cycle();
    checkOutput("idle busy", busy, 0);
    checkOutput("idle leds", leds, 0);

    foreach (table_v[i])
      run_tally($sformatf("vec%0d", i), table_v[i].v1, table_v[i].v2, table_v[i].v3, table_v[i].v4,
                table_v[i].e_id, table_v[i].e_cnt, table_v[i].e_tie, table_v[i].e_tot, 1'b0);

    // Inputs change and start re-asserts mid-scan: one done, original snapshot used.
    next_cycle();
    applyStimulus(5, 3, 4, 1, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      next_cycle();
      if (k == 1) start = 1'b0;
      if (k == 2) cand2_vote = 8'd200;
      if (k == 3) start = 1'b1;
      if (k == 4) start = 1'b0;
      checkOutput($sformatf("restart done c%0d", k), done, (k == 5) ? 1 : 0);
      if (k == 5) begin
        checkOutput("restart winner_id", winner_id, 1);
        checkOutput("restart winner_count", winner_count, 5);
        checkOutput("restart tie", tie, 0);
        checkOutput("restart total", total_votes, 13);
      end
    end

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 4; i++)
        r[i] = (n % 2 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      model(r[0], r[1], r[2], r[3], id, cnt, t, tot);
      run_tally($sformatf("rand%0d", n), r[0], r[1], r[2], r[3], id, cnt, t, tot, 1'b1);
    end

    // Reset during cycle 3 of a scan aborts it without a done pulse.
    next_cycle();
    applyStimulus(9, 9, 9, 9, 1'b1);
    next_cycle();
    start = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort done", done, 0);
    checkOutput("abort winner_id", winner_id, 0);
    checkOutput("abort winner_count", winner_count, 0);
    checkOutput("abort tie", tie, 0);
    checkOutput("abort total", total_votes, 0);
    checkOutput("abort leds", leds, 0);
    for (int k = 5; k <= 8; k++) begin
      next_cycle();
      checkOutput($sformatf("abort done c%0d", k), done, 0);
      checkOutput($sformatf("abort busy c%0d", k), busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vote_result_tally.md
VOTE_RESULT_TALLY -- requirements
Module: vote_result_tally

Interface
Parameters:
REQ-001 SHALL provide parameter BLINK_CYCLES, default 10: number of cycles per LED on/off phase in tie display.
REQ-002 SHALL provide parameter TOTAL_W, default 10: width of the total_votes output.

Ports:
REQ-003 SHALL provide clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL provide reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide start  input  1  tally request, sampled every cycle.
REQ-006 SHALL provide cand1_vote..cand4_vote  input  8 each  per-candidate vote counts from the vote logger.
REQ-007 SHALL provide busy  output  1  high while scanning.
REQ-008 SHALL provide done  output  1  one-cycle pulse; results valid in that cycle.
REQ-009 SHALL provide winner_id  output  3  0 = no votes; 1..4 = winning candidate.
REQ-010 SHALL provide winner_count  output  8  vote count of the winner.
REQ-011 SHALL provide tie  output  1  two or more candidates share a nonzero top count.
REQ-012 SHALL provide total_votes  output  TOTAL_W  sum of the four counts.
REQ-013 SHALL provide leds  output  8  result display.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, DONE, SHOW.
REQ-015 SHALL, in IDLE or SHOW with start=1, snapshot all four counts into internal registers and enter SCAN next cycle.
REQ-016 SHALL ignore start while in SCAN or DONE.
REQ-017 SHALL, in SCAN, process exactly one candidate per cycle in order 1,2,3,4, then go to DONE; busy=1 only in SCAN.
REQ-018 SHALL use snapshot values only; input changes after the start cycle do not affect the result.
REQ-019 SHALL clear running best=0, best_id=0, tie=0, sum=0 on SCAN entry.
REQ-020 SHALL, per candidate i with count c: c>best -> best=c, best_id=i, tie=0; c==best and c!=0 -> tie=1, best_id unchanged (lowest index wins); else no change.
REQ-021 SHALL accumulate sum zero-extended to TOTAL_W bits; max 1020, no overflow at default width.
REQ-022 SHALL keep latency fixed: start high in cycle 0 -> busy high cycles 1-4 -> done high in cycle 5 -> SHOW from cycle 6.
REQ-023 SHALL update winner_id, winner_count, tie and total_votes only on entry to DONE, holding them until the next DONE or reset.
REQ-024 SHALL drive leds=0x00 in IDLE and SCAN.
REQ-025 SHALL, in DONE and SHOW with tie=0, drive leds=winner_count steady.
REQ-026 SHALL, in DONE and SHOW with tie=1, alternate leds between winner_count (on phase) and 0x00 (off phase), each phase BLINK_CYCLES cycles, starting with the on phase in the DONE cycle.
REQ-027 SHALL reset the blink counter on DONE entry and hold it at 0 outside DONE/SHOW.
REQ-028 SHALL remain in SHOW until start or reset.
REQ-029 SHALL yield winner_id=0, winner_count=0, tie=0 and leds=0x00 when all counts are zero.

Reset
REQ-030 SHALL, on reset, go to IDLE next cycle with busy=0, done=0, winner_id=0, winner_count=0, tie=0, total_votes=0, leds=0x00 and blink counter 0.
REQ-031 SHALL give reset priority over start, including mid-SCAN, where no done pulse is produced.

Verification
REQ-032 Reset for 2 cycles -> all outputs 0, state IDLE.
REQ-033 Counts 5,9,3,2 with start pulse in cycle 0 -> busy high cycles 1-4; done in cycle 5 with winner_id=2, winner_count=9, tie=0, total_votes=19; leds=0x09 steady.
REQ-034 Counts 7,3,7,1 with start -> winner_id=1, winner_count=7, tie=1, total_votes=18; leds 0x07 for 10 cycles, then 0x00 for 10 cycles, repeating.
REQ-035 Counts 0,0,0,0 with start -> winner_id=0, tie=0, total_votes=0, leds=0x00; counts 255 x4 -> total_votes=1020, winner_id=1, tie=1.
REQ-036 Start in cycle 0, cand2_vote changed 3->200 in cycle 2, second start in cycle 3 -> single done in cycle 5 using original values.
REQ-037 Reset asserted in cycle 3 of a scan -> no done pulse, outputs 0, busy=0 from cycle 4.
